// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Bundles the byte port, the strobe, the valid/ready port and
//                the status signals of the UART receive FIFO.
//                master : UART receiver plus consumer (drives in, in_clk,
//                         out_ready, ovf_clr).
//                slave  : the FIFO (drives out, out_valid, count, overflow).
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int D = 16
);
    localparam int AW = $clog2(D);

    logic [7:0]  in;         // byte from receiver
    logic        in_clk;     // receiver update strobe, level, >= 1 cycle
    logic [7:0]  out;        // head-of-FIFO byte, 0 when empty
    logic        out_valid;  // FIFO non-empty
    logic        out_ready;  // consumer takes out this cycle
    logic [AW:0] count;      // bytes stored, 0..D
    logic        overflow;   // sticky drop flag
    logic        ovf_clr;    // synchronous clear of overflow

    modport master (
        output in, in_clk, out_ready, ovf_clr,
        input  out, out_valid, count, overflow
    );

    modport slave (
        input  in, in_clk, out_ready, ovf_clr,
        output out, out_valid, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO behind the UART receiver.
//                One byte is captured per rising edge of the receiver strobe,
//                up to D bytes are held, and they are offered on a
//                valid/ready port. A byte arriving while full is dropped and
//                flagged in a sticky overflow bit.
//  Ports       : clk    system clock (shared with the receiver)
//                rst_n  asynchronous active-low reset
//                bus    uart_rx_fifo_if.slave: in, in_clk, out, out_valid,
//                       out_ready, count, overflow, ovf_clr
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int D = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_rx_fifo_if.slave      bus
);
    localparam int            AW      = $clog2(D);
    localparam logic [AW:0]   c_depth = (AW + 1)'(D);

    logic [7:0]    r_mem [D];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_in_clk_d;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_write;
    logic          w_drop;

    // One push per strobe, whatever its width.
    assign w_push  = bus.in_clk & ~r_in_clk_d;
    assign w_pop   = (r_count != '0) & bus.out_ready;
    assign w_full  = (r_count == c_depth);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Storage is not reset; only the bookkeeping decides what is valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            // Starts high so a strobe already asserted at release is ignored.
            r_in_clk_d <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_in_clk_d <= bus.in_clk;

            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A drop on the same edge as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.out       = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.out_valid = (r_count != '0);
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo (depth 4). A queue
//                model follows the FIFO rules; a negedge process compares
//                every output against it each cycle, and directed scenarios
//                add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo_if #(.D(D)) bus ();

    uart_rx_fifo #(.D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] q[$];
    bit         m_ovf      = 1'b0;
    bit         m_strobe_d = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf      = 1'b0;
            m_strobe_d = 1'b1;
        end else begin
            bit push, pop, drop;
            push = bus.in_clk && !m_strobe_d;
            pop  = (q.size() > 0) && bus.out_ready;
            drop = 1'b0;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < D) q.push_back(bus.in);
                else              drop = 1'b1;
            end
            if (drop)              m_ovf = 1'b1;
            else if (bus.ovf_clr)  m_ovf = 1'b0;
            m_strobe_d = bus.in_clk;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_count",    32'(bus.count),     32'(q.size()));
            chk("model_valid",    32'(bus.out_valid), 32'(q.size() != 0));
            chk("model_out",      32'(bus.out),       (q.size() != 0) ? 32'(q[0]) : 32'h0);
            chk("model_overflow", 32'(bus.overflow),  32'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in     = b;
        bus.in_clk = 1'b1;
        cyc();
        bus.in_clk = 1'b0;
        cyc();
    endtask

    initial begin
        logic [7:0] exp_drain [5];
        logic [7:0] got;

        exp_drain[0] = 8'h01; exp_drain[1] = 8'h02; exp_drain[2] = 8'h03;
        exp_drain[3] = 8'h04; exp_drain[4] = 8'h55;

        bus.in        = 8'h00;
        bus.in_clk    = 1'b1;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (3) cyc();
        chk("reset_count", 32'(bus.count),     32'h0);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_out",   32'(bus.out),       32'h0);
        chk("reset_ovf",   32'(bus.overflow),  32'h0);

        // Strobe held high through reset release: no capture.
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("held_strobe_count", 32'(bus.count),     32'h0);
        chk("held_strobe_valid", 32'(bus.out_valid), 32'h0);
        bus.in_clk = 1'b0;
        cyc();
        bus.in     = 8'hA5;
        bus.in_clk = 1'b1;
        cyc();
        chk("first_push_count", 32'(bus.count), 32'h1);
        chk("first_push_out",   32'(bus.out),   32'hA5);
        bus.in_clk    = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("first_pop_count", 32'(bus.count), 32'h0);

        // Wide strobe: one entry.
        bus.in     = 8'h3C;
        bus.in_clk = 1'b1;
        repeat (3) cyc();
        bus.in_clk = 1'b0;
        cyc();
        chk("wide_strobe_count", 32'(bus.count), 32'h1);
        chk("wide_strobe_out",   32'(bus.out),   32'h3C);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // Fill and overflow.
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("full_count", 32'(bus.count), 32'h4);
        chk("full_ovf",   32'(bus.overflow), 32'h0);
        push(8'h05);
        chk("ovf_count", 32'(bus.count),    32'h4);
        chk("ovf_set",   32'(bus.overflow), 32'h1);

        // Clear on the same edge as a dropped push: set wins.
        bus.in      = 8'h66;
        bus.in_clk  = 1'b1;
        bus.ovf_clr = 1'b1;
        cyc();
        bus.in_clk  = 1'b0;
        bus.ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(bus.overflow), 32'h1);
        cyc();
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        chk("ovf_clear", 32'(bus.overflow), 32'h0);

        // Full: push and pop on the same edge.
        bus.in        = 8'h55;
        bus.in_clk    = 1'b1;
        bus.out_ready = 1'b1;
        got = bus.out;
        cyc();
        bus.in_clk = 1'b0;
        chk("drain_0",         32'(got),          32'(exp_drain[0]));
        chk("full_pushpop_cnt", 32'(bus.count),   32'h4);
        chk("full_pushpop_ovf", 32'(bus.overflow), 32'h0);
        for (int k = 1; k < 5; k++) begin
            got = bus.out;
            chk($sformatf("drain_%0d", k), 32'(got), 32'(exp_drain[k]));
            cyc();
        end
        bus.out_ready = 1'b0;
        chk("drained_out",   32'(bus.out),       32'h0);
        chk("drained_valid", 32'(bus.out_valid), 32'h0);

        // Back-to-back bytes with a reset in the middle.
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            bus.in     = 8'($urandom);
            bus.in_clk = 1'b1;
            cyc();
            if (n == 9) begin
                chk("pre_reset_count", 32'(bus.count), 32'h1);
                #2 rst_n = 1'b0;
                #1;
                chk("async_reset_count", 32'(bus.count),     32'h0);
                chk("async_reset_valid", 32'(bus.out_valid), 32'h0);
                cyc();
                rst_n = 1'b1;
            end
            bus.in_clk = 1'b0;
            cyc();
        end

        // Random traffic: slow consumer, then fast consumer.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 200; c++) begin
                bus.in        = 8'($urandom);
                bus.in_clk    = ($urandom_range(0, 2) == 0);
                bus.out_ready = (ph == 0) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
                bus.ovf_clr   = ($urandom_range(0, 15) == 0);
                cyc();
            end
        end
        bus.in_clk    = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
